// File: rtl/barrel_shifter_pkg.sv
// Shared types and helpers for the pipelined barrel shifter.
// Operation encodings, the reserved-op constant and a constant-foldable clog2.
package barrel_shifter_pkg;

  typedef enum logic [2:0] {
    OP_ROR = 3'b000,
    OP_ROL = 3'b001,
    OP_SRL = 3'b010,
    OP_SRA = 3'b011,
    OP_SLL = 3'b100
  } shift_op_e;

  // Any encoding at or above this value passes the operand through untouched.
  localparam logic [2:0] OP_RESERVED = 3'b101;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/pipelined_barrel_shifter_stage.sv
// One pipeline stage: moves the word by 2**STAGE positions when its shamt bit is set.
// Carry tracking is compiled in only with SHIFTER_CARRY_OUT_EN.
module shifter_stage
  import barrel_shifter_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STAGE = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic                      in_valid,
  input  logic [WIDTH-1:0]          in_data,
  input  logic [clog2(WIDTH)-1:0]   in_shamt,
  input  logic [2:0]                in_op,
  input  logic                      in_sign,
`ifdef SHIFTER_CARRY_OUT_EN
  input  logic                      in_carry,
  output logic                      out_carry,
`endif
  output logic                      out_valid,
  output logic [WIDTH-1:0]          out_data,
  output logic [clog2(WIDTH)-1:0]   out_shamt,
  output logic [2:0]                out_op,
  output logic                      out_sign
);

  localparam int SHW  = clog2(WIDTH);
  localparam int DIST = 1 << STAGE;

  logic [WIDTH-1:0] data_d, data_q;
  logic [SHW-1:0]   shamt_q;
  logic [2:0]       op_q;
  logic             sign_q, valid_q;

  always_comb begin
    data_d = in_data;
    if (in_shamt[STAGE]) begin
      case (in_op)
        OP_ROR:  data_d = (in_data >> DIST) | (in_data << (WIDTH - DIST));
        OP_ROL:  data_d = (in_data << DIST) | (in_data >> (WIDTH - DIST));
        OP_SRL:  data_d = in_data >> DIST;
        OP_SRA:  data_d = (in_data >> DIST) | ({WIDTH{in_sign}} << (WIDTH - DIST));
        OP_SLL:  data_d = in_data << DIST;
        default: data_d = in_data;
      endcase
    end
  end

  // NOTE: the datapath registers are reset along with valid so the last stage reads 0 after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: state updates use <= so every stage samples its neighbour's pre-edge value.
      valid_q <= 1'b0;
      data_q  <= '0;
      shamt_q <= '0;
      op_q    <= 3'b000;
      sign_q  <= 1'b0;
    end else if (en) begin
      valid_q <= in_valid;
      data_q  <= data_d;
      shamt_q <= in_shamt;
      op_q    <= in_op;
      sign_q  <= in_sign;
    end
  end

`ifdef SHIFTER_CARRY_OUT_EN
  logic carry_d, carry_q;

  // The last stage that actually moves the word decides the final carry.
  always_comb begin
    carry_d = in_carry;
    if (in_shamt[STAGE]) begin
      case (in_op)
        OP_ROR:         carry_d = data_d[WIDTH-1];
        OP_ROL:         carry_d = data_d[0];
        OP_SRL, OP_SRA: carry_d = in_data[DIST-1];
        OP_SLL:         carry_d = in_data[WIDTH-DIST];
        default:        carry_d = in_carry;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst)     carry_q <= 1'b0;
    else if (en) carry_q <= carry_d;
  end

  assign out_carry = carry_q;
`endif

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_shamt = shamt_q;
  assign out_op    = op_q;
  assign out_sign  = sign_q;

endmodule

// File: rtl/pipelined_barrel_shifter.sv
// Fully pipelined rotate/shift unit, one register stage per shift-amount bit, global stall.
// Optional out_carry port enabled by defining SHIFTER_CARRY_OUT_EN.
module pipelined_barrel_shifter
  import barrel_shifter_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [WIDTH-1:0]        in_data,
  input  logic [clog2(WIDTH)-1:0] in_shamt,
  input  logic [2:0]              in_op,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH-1:0]        out_data
`ifdef SHIFTER_CARRY_OUT_EN
  ,
  output logic                    out_carry
`endif
);

  localparam int SHW = clog2(WIDTH);

  logic [SHW:0][WIDTH-1:0] data_s;
  logic [SHW:0][SHW-1:0]   shamt_s;
  logic [SHW:0][2:0]       op_s;
  logic [SHW:0]            sign_s;
  logic [SHW:0]            valid_s;
  logic                    advance;

  // The whole pipe moves together; only a held result at the tail stops it.
  assign advance  = out_ready || !out_valid;
  assign in_ready = advance && !rst;

  assign data_s[0]  = in_data;
  assign shamt_s[0] = in_shamt;
  assign op_s[0]    = in_op;
  assign sign_s[0]  = in_data[WIDTH-1];
  assign valid_s[0] = in_valid;

`ifdef SHIFTER_CARRY_OUT_EN
  logic [SHW:0] carry_s;
  assign carry_s[0] = 1'b0;
  assign out_carry  = carry_s[SHW];
`endif

  for (genvar k = 0; k < SHW; k++) begin : g_stage
    shifter_stage #(
      .WIDTH (WIDTH),
      .STAGE (k)
    ) u_stage (
      .clk       (clk),
      .rst       (rst),
      .en        (advance),
      .in_valid  (valid_s[k]),
      .in_data   (data_s[k]),
      .in_shamt  (shamt_s[k]),
      .in_op     (op_s[k]),
      .in_sign   (sign_s[k]),
`ifdef SHIFTER_CARRY_OUT_EN
      .in_carry  (carry_s[k]),
      .out_carry (carry_s[k+1]),
`endif
      .out_valid (valid_s[k+1]),
      .out_data  (data_s[k+1]),
      .out_shamt (shamt_s[k+1]),
      .out_op    (op_s[k+1]),
      .out_sign  (sign_s[k+1])
    );
  end

  assign out_valid = valid_s[SHW];
  assign out_data  = data_s[SHW];

  logic unused_tail;
  assign unused_tail = ^{shamt_s[SHW], op_s[SHW], sign_s[SHW]};

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Directed self-checking bench for pipelined_barrel_shifter (WIDTH=32 and WIDTH=8 instances).
// Carry checks are compiled in when SHIFTER_CARRY_OUT_EN is defined.
module tb_pipelined_barrel_shifter;
  import barrel_shifter_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_data, out_data;
  logic [4:0]  in_shamt;
  logic [2:0]  in_op;

  logic        in_valid8, in_ready8, out_valid8, out_ready8;
  logic [7:0]  in_data8, out_data8;
  logic [2:0]  in_shamt8;
  logic [2:0]  in_op8;

`ifdef SHIFTER_CARRY_OUT_EN
  logic out_carry, out_carry8;
`endif

  int errors = 0;
  int checks = 0;

  pipelined_barrel_shifter #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_shamt  (in_shamt),
    .in_op     (in_op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
`ifdef SHIFTER_CARRY_OUT_EN
    ,
    .out_carry (out_carry)
`endif
  );

  pipelined_barrel_shifter #(.WIDTH(8)) dut8 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid8),
    .in_ready  (in_ready8),
    .in_data   (in_data8),
    .in_shamt  (in_shamt8),
    .in_op     (in_op8),
    .out_valid (out_valid8),
    .out_ready (out_ready8),
    .out_data  (out_data8)
`ifdef SHIFTER_CARRY_OUT_EN
    ,
    .out_carry (out_carry8)
`endif
  );

  // Presents one beat, then waits (bounded) for its result; lat = 0 means timeout.
  task automatic run32(input logic [31:0] d, input logic [4:0] s, input logic [2:0] op,
                       output logic [31:0] res, output logic c, output int lat);
    @(negedge clk);
    in_valid  = 1'b1;
    in_data   = d;
    in_shamt  = s;
    in_op     = op;
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      if (out_valid) begin
        lat = i;
        break;
      end
      @(negedge clk);
    end
    res = out_data;
`ifdef SHIFTER_CARRY_OUT_EN
    c = out_carry;
`else
    c = 1'b0;
`endif
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL reset_out_data: got %h expected 00000000", out_data); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
    checks++; if (out_valid8 !== 1'b0) begin errors++; $display("FAIL reset_out_valid8: got %b expected 0", out_valid8); end
`ifdef SHIFTER_CARRY_OUT_EN
    checks++; if (out_carry !== 1'b0) begin errors++; $display("FAIL reset_out_carry: got %b expected 0", out_carry); end
`endif
    rst = 1'b0;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL post_reset_valid: got %b expected 0", out_valid); end
    checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL post_reset_data: got %h expected 00000000", out_data); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready: got %b expected 1", in_ready); end
  endtask

  task automatic test_ror();
    logic [31:0] res;
    logic        c;
    int          lat;
    run32(32'h8000_0001, 5'd1, OP_ROR, res, c, lat);
    checks++; if (lat !== 5) begin errors++; $display("FAIL ror_latency: got %0d expected 5", lat); end
    checks++; if (res !== 32'hC000_0000) begin errors++; $display("FAIL ror_data: got %h expected c0000000", res); end
`ifdef SHIFTER_CARRY_OUT_EN
    checks++; if (c !== 1'b1) begin errors++; $display("FAIL ror_carry: got %b expected 1", c); end
`endif
  endtask

  task automatic test_shifts();
    logic [31:0] res;
    logic        c;
    int          lat;
    run32(32'hF000_0000, 5'd4, OP_SRA, res, c, lat);
    checks++; if (res !== 32'hFF00_0000) begin errors++; $display("FAIL sra_data: got %h expected ff000000", res); end
    run32(32'hF000_0000, 5'd4, OP_SRL, res, c, lat);
    checks++; if (res !== 32'h0F00_0000) begin errors++; $display("FAIL srl_data: got %h expected 0f000000", res); end
    run32(32'h0000_0001, 5'd31, OP_SLL, res, c, lat);
    checks++; if (res !== 32'h8000_0000) begin errors++; $display("FAIL sll_data: got %h expected 80000000", res); end
    run32(32'h8000_0000, 5'd1, OP_ROL, res, c, lat);
    checks++; if (res !== 32'h0000_0001) begin errors++; $display("FAIL rol_data: got %h expected 00000001", res); end
`ifdef SHIFTER_CARRY_OUT_EN
    checks++; if (c !== 1'b1) begin errors++; $display("FAIL rol_carry: got %b expected 1", c); end
    run32(32'h0000_0008, 5'd4, OP_SRL, res, c, lat);
    checks++; if (c !== 1'b1) begin errors++; $display("FAIL srl_carry: got %b expected 1", c); end
    run32(32'h4000_0000, 5'd2, OP_SLL, res, c, lat);
    checks++; if (c !== 1'b1) begin errors++; $display("FAIL sll_carry: got %b expected 1", c); end
    run32(32'hF000_0000, 5'd4, OP_SRA, res, c, lat);
    checks++; if (c !== 1'b0) begin errors++; $display("FAIL sra_carry: got %b expected 0", c); end
`endif
  endtask

  task automatic test_shamt0_reserved();
    logic [31:0] res;
    logic        c;
    int          lat;
    for (int op = 0; op < 8; op++) begin
      if (op < 5) run32(32'hDEAD_BEEF, 5'd0, 3'(op), res, c, lat);
      else        run32(32'hDEAD_BEEF, 5'd7, 3'(op), res, c, lat);
      checks++;
      if (res !== 32'hDEAD_BEEF) begin
        errors++; $display("FAIL passthru_op%0d: got %h expected deadbeef", op, res);
      end
      checks++;
      if (c !== 1'b0) begin
        errors++; $display("FAIL passthru_carry_op%0d: got %b expected 0", op, c);
      end
    end
  endtask

  task automatic test_back_pressure();
    logic [31:0] exp_v [8];
    logic [31:0] got [8];
    logic [31:0] hold;
    int sent, rcv, extra;
    exp_v = '{32'h1234_5678, 32'h2468_ACF0, 32'h48D1_59E0, 32'h91A2_B3C0,
              32'h2345_6781, 32'h468A_CF02, 32'h8D15_9E04, 32'h1A2B_3C09};
    sent = 0; rcv = 0; extra = 0; hold = '0;
    for (int i = 0; i < 8; i++) got[i] = '0;
    for (int cyc = 0; cyc < 60 && rcv < 8; cyc++) begin
      @(negedge clk);
      out_ready = !(cyc >= 6 && cyc <= 8);
      if (sent < 8) begin
        in_valid = 1'b1; in_data = 32'h1234_5678; in_shamt = 5'(sent); in_op = OP_ROL;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (cyc >= 6 && cyc <= 8) begin
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready c%0d: got %b expected 0", cyc, in_ready); end
        if (cyc == 6) hold = out_data;
        else begin
          checks++;
          if (out_data !== hold) begin errors++; $display("FAIL stall_data_stable c%0d: got %h expected %h", cyc, out_data, hold); end
        end
      end
      if (in_valid && in_ready) sent++;
      if (out_valid && out_ready) begin
        if (rcv < 8) got[rcv] = out_data;
        rcv++;
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (8) begin
      @(negedge clk);
      if (out_valid) extra++;
    end
    checks++; if (rcv !== 8) begin errors++; $display("FAIL bp_count: got %0d expected 8", rcv); end
    checks++; if (extra !== 0) begin errors++; $display("FAIL bp_extra: got %0d expected 0", extra); end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (got[i] !== exp_v[i]) begin errors++; $display("FAIL bp_beat%0d: got %h expected %h", i, got[i], exp_v[i]); end
    end
  endtask

  task automatic test_reset_midflight();
    int rises;
    rises = 0;
    @(negedge clk);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = 32'h1111_1111 * (i + 1); in_shamt = 5'd1; in_op = OP_ROR;
      @(negedge clk);
    end
    in_valid = 1'b0;
    @(negedge clk);
    if (out_valid) rises++;
    rst = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL midflight_in_ready: got %b expected 0", in_ready); end
    repeat (2) begin
      @(negedge clk);
      if (out_valid) rises++;
    end
    rst = 1'b0;
    @(negedge clk);
    checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL midflight_data: got %h expected 00000000", out_data); end
`ifdef SHIFTER_CARRY_OUT_EN
    checks++; if (out_carry !== 1'b0) begin errors++; $display("FAIL midflight_carry: got %b expected 0", out_carry); end
`endif
    repeat (12) begin
      if (out_valid) rises++;
      @(negedge clk);
    end
    checks++; if (rises !== 0) begin errors++; $display("FAIL midflight_valid_rises: got %0d expected 0", rises); end
  endtask

  task automatic test_width8();
    int lat;
    @(negedge clk);
    in_valid8 = 1'b1; in_data8 = 8'h81; in_shamt8 = 3'd3; in_op8 = OP_ROR; out_ready8 = 1'b1;
    @(negedge clk);
    in_valid8 = 1'b0;
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      if (out_valid8) begin
        lat = i;
        break;
      end
      @(negedge clk);
    end
    checks++; if (lat !== 3) begin errors++; $display("FAIL w8_latency: got %0d expected 3", lat); end
    checks++; if (out_data8 !== 8'h30) begin errors++; $display("FAIL w8_data: got %h expected 30", out_data8); end
`ifdef SHIFTER_CARRY_OUT_EN
    checks++; if (out_carry8 !== 1'b0) begin errors++; $display("FAIL w8_carry: got %b expected 0", out_carry8); end
`endif
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; in_data = '0; in_shamt = '0; in_op = '0; out_ready = 1'b1;
    in_valid8 = 1'b0; in_data8 = '0; in_shamt8 = '0; in_op8 = '0; out_ready8 = 1'b1;
    test_reset();
    test_ror();
    test_shifts();
    test_shamt0_reserved();
    test_back_pressure();
    test_reset_midflight();
    test_width8();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipelined_barrel_shifter.md
# pipelined_barrel_shifter

Parametrised, fully pipelined barrel shifter and rotator. It performs rotate-right, rotate-left, logical shift right/left and arithmetic shift right on a WIDTH-bit operand. There is one register stage per shift bit, and valid/ready handshakes on both sides. It sits in the datapath between operand fetch and the writeback buffer, and replaces the single-cycle 32-bit right rotator wherever the shift must close timing at full clock rate.

## Interface
- WIDTH, 32: operand width; power of two, 8..128.
- SHW, $clog2(WIDTH): shift-amount width; derived, not overridable.
- clk  input  1  clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  input beat present.
- in_ready  output  1  block accepts the beat this cycle.
- in_data  input  WIDTH  operand.
- in_shamt  input  SHW  shift amount, 0..WIDTH-1.
- in_op  input  3  operation select (see Operation).
- out_valid  output  1  result present.
- out_ready  input  1  downstream accepts the result.
- out_data  output  WIDTH  result.
- out_carry  output  1  last bit shifted out (only with SHIFTER_CARRY_OUT_EN).

## Operation
- in_op encoding:
  - 000: ROR.
  - 001: ROL.
  - 010: SRL (zero fill).
  - 011: SRA (fill with in_data[WIDTH-1]).
  - 100: SLL (zero fill).
  - 101..111: reserved; out_data = in_data unchanged, out_carry = 0.
- Structure: SHW stages. Stage k conditionally moves the word by 2^k positions under shamt bit k, in the direction and fill given by op.
- Stage registers:
  - Each stage register holds data, the remaining shamt bits, op, the sign bit (SRA), carry and valid.
  - Left operations are resolved per stage. No reversal is applied at the output.
- in_shamt = 0: out_data = in_data for every op; out_carry = 0.
- Handshake:
  - Beat accepted when in_valid && in_ready.
  - Result consumed when out_valid && out_ready.
- Global-stall pipeline:
  - advance = out_ready || !out_valid.
  - in_ready = advance && !rst.
  - When advance = 0, every stage register holds its value.
  - out_data, out_carry and out_valid stay stable until consumed.
- Bubbles are not collapsed. An empty slot travels through the pipe like data.
- out_data is don't-care when out_valid = 0, but the implementation must not toggle it during a stall.

## Timing
- Latency: exactly SHW cycles from acceptance to out_valid, with no stalls (5 cycles at WIDTH = 32).
- Throughput: one beat per cycle while out_ready is held high.
- Reset, while rst = 1 and on the cycle after release:
  - All stage valid bits are 0.
  - out_valid = 0, out_data = 0, out_carry = 0.
  - in_ready = 0 while rst is asserted.
- Reset mid-operation: all in-flight beats are discarded; nothing emerges after release.
- Simultaneous accept and consume in one cycle is legal and keeps full throughput.
- in_valid may drop after a beat is accepted. A held, unaccepted beat must keep in_data, in_shamt and in_op stable.

## Configuration
- SHIFTER_CARRY_OUT_EN defined:
  - out_carry port exists and is pipelined alongside the data.
  - SRL/SRA: carry = in_data[shamt-1].
  - SLL: carry = in_data[WIDTH-shamt].
  - ROR: carry = out_data[WIDTH-1].
  - ROL: carry = out_data[0].
  - carry = 0 when shamt = 0.
- SHIFTER_CARRY_OUT_EN undefined: port and carry registers absent; everything else is identical.

## Structure
- barrel_shifter_pkg holds:
  - shift_op_e enum (3 bits, encodings above).
  - Reserved-op constant.
  - clog2 helper function.
- Sub-module shifter_stage, parametrised by WIDTH and STAGE (distance 2^STAGE):
  - One combinational shift/rotate mux plus its pipeline register.
  - Enable tied to advance.
  - Instantiated SHW times by generate.

## Test plan
WIDTH = 32 unless stated.
- ROR: in_data = 0x8000_0001, in_shamt = 1, in_op = ROR, out_ready = 1 -> out_data = 0xC000_0000 exactly 5 cycles later; out_carry = 1.
- SRA vs SRL: in_data = 0xF000_0000, in_shamt = 4 -> SRA gives 0xFF00_0000, SRL gives 0x0F00_0000. SLL of 0x0000_0001 by 31 -> 0x8000_0000.
- Back-pressure:
  - Stream 8 beats with ROL by 0..7 on 0x1234_5678.
  - Hold out_ready = 0 for 3 cycles mid-stream.
  - Expected: in_ready = 0 during the stall, out_data stable, all 8 results in order with no loss or duplication.
- Reset mid-flight: assert rst 2 cycles after 3 beats are accepted -> out_valid never rises for those beats; all outputs are 0 after reset.
- Shamt 0 and reserved op: shamt = 0 on all ops, and op = 101 with shamt = 7, each on 0xDEAD_BEEF -> out_data = 0xDEAD_BEEF, out_carry = 0.
- WIDTH = 8 instance: 0x81 ROR 3 -> 0x30, with latency 3 cycles.
